// File: rtl/gpio_irq_periph.sv
// GPIO peripheral for the tinyQV bus: outputs with set/clear/toggle aliases, pad mux,
// synchronised inputs and per-pin edge/level interrupts with write-1-to-clear pending bits.
module gpio_irq_periph #(
  parameter int unsigned NUM_PINS    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] OUT_SEL_RST = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel,
  input  logic [5:0]          addr,
  input  logic [1:0]          write_n,
  input  logic [1:0]          read_n,
  input  logic [31:0]         data_in,
  output logic [31:0]         data_out,
  input  logic [NUM_PINS-1:0] gpio_in,
  input  logic [NUM_PINS-1:0] func_out,
  output logic [NUM_PINS-1:0] pad_out,
  output logic                irq
);

  localparam int unsigned MODE_W = 2 * NUM_PINS;
  localparam int unsigned CNT_W  = 3;

  localparam logic [3:0] REG_OUT  = 4'd0;
  localparam logic [3:0] REG_IN   = 4'd1;
  localparam logic [3:0] REG_SET  = 4'd2;
  localparam logic [3:0] REG_CLR  = 4'd3;
  localparam logic [3:0] REG_TGL  = 4'd4;
  localparam logic [3:0] REG_SEL  = 4'd5;
  localparam logic [3:0] REG_IEN  = 4'd6;
  localparam logic [3:0] REG_MODE = 4'd7;
  localparam logic [3:0] REG_PEND = 4'd8;

  logic [NUM_PINS-1:0] out_q, out_sel_q, irq_en_q, pend_q, prev_q;
  logic [NUM_PINS-1:0] out_d, out_sel_d, irq_en_d, pend_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] synced, rise, fall, ev, w1c;
  logic [CNT_W-1:0]    blank_q, blank_d;
  logic [3:0]          idx;
  logic                wr;
  logic [31:0]         wmask, wdata;
  logic [NUM_PINS-1:0] wd, wm;
  logic                unused_bits;

  assign idx    = addr[5:2];
  assign wr     = sel && (write_n != 2'b11);
  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev_q;
  assign fall   = ~synced & prev_q;
  assign wdata  = data_in & wmask;
  assign wd     = wdata[NUM_PINS-1:0];
  assign wm     = wmask[NUM_PINS-1:0];

  assign pad_out = (out_sel_q & out_q) | (~out_sel_q & func_out);
  assign irq     = |(pend_q & irq_en_q);
  assign unused_bits = &{1'b0, read_n, addr[1:0], wdata, wmask};

  // Byte lanes enabled by the write size
  always_comb begin
    wmask = 32'hFFFF_FFFF;
    case (write_n)
      2'b00:   wmask = 32'h0000_00FF;
      2'b01:   wmask = 32'h0000_FFFF;
      default: wmask = 32'hFFFF_FFFF;
    endcase
  end

  // Register writes, interrupt event detection and blanking countdown
  always_comb begin
    out_d     = out_q;
    out_sel_d = out_sel_q;
    irq_en_d  = irq_en_q;
    mode_d    = mode_q;
    w1c       = '0;
    ev        = '0;
    pend_d    = pend_q;
    blank_d   = blank_q;
    if (wr) begin
      case (idx)
        REG_OUT:  out_d     = (out_q & ~wm) | wd;
        REG_SET:  out_d     = out_q | wd;
        REG_CLR:  out_d     = out_q & ~wd;
        REG_TGL:  out_d     = out_q ^ wd;
        REG_SEL:  out_sel_d = (out_sel_q & ~wm) | wd;
        REG_IEN:  irq_en_d  = (irq_en_q & ~wm) | wd;
        REG_MODE: mode_d    = (mode_q & ~wmask[MODE_W-1:0]) | wdata[MODE_W-1:0];
        REG_PEND: w1c       = wd;
        default:  ;
      endcase
    end
    for (int i = 0; i < NUM_PINS; i++) begin
      case (mode_q[2*i +: 2])
        2'b00:   ev[i] = rise[i];
        2'b01:   ev[i] = fall[i];
        2'b10:   ev[i] = rise[i] | fall[i];
        default: ev[i] = 1'b0;
      endcase
      // Event set takes priority over a same-cycle clear
      if (mode_q[2*i +: 2] == 2'b11)
        pend_d[i] = synced[i];
      else
        pend_d[i] = (pend_q[i] & ~w1c[i]) | (ev[i] & (blank_q == '0));
    end
    if (blank_q != '0)
      blank_d = blank_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      out_sel_q <= OUT_SEL_RST[NUM_PINS-1:0];
      irq_en_q  <= '0;
      mode_q    <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
      blank_q   <= CNT_W'(SYNC_STAGES + 1);
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      out_q     <= out_d;
      out_sel_q <= out_sel_d;
      irq_en_q  <= irq_en_d;
      mode_q    <= mode_d;
      pend_q    <= pend_d;
      prev_q    <= synced;
      blank_q   <= blank_d;
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Combinational read mux
  always_comb begin
    data_out = 32'hFFFF_FFFF;
    if (sel) begin
      case (idx)
        REG_OUT, REG_SET, REG_CLR, REG_TGL: data_out = 32'(out_q);
        REG_IN:   data_out = 32'(synced);
        REG_SEL:  data_out = 32'(out_sel_q);
        REG_IEN:  data_out = 32'(irq_en_q);
        REG_MODE: data_out = 32'(mode_q);
        REG_PEND: data_out = 32'(pend_q);
        default:  data_out = 32'hFFFF_FFFF;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_irq_periph.sv
// Directed self-checking bench for gpio_irq_periph (NUM_PINS=8, SYNC_STAGES=2).
module tb_gpio_irq_periph;

  logic        clk, rst, sel, irq;
  logic [5:0]  addr;
  logic [1:0]  write_n, read_n;
  logic [31:0] data_in, data_out, v;
  logic [7:0]  gpio_in, func_out, pad_out, exp_out;
  int          checks = 0;
  int          errors = 0;

  gpio_irq_periph #(.NUM_PINS(8), .SYNC_STAGES(2), .OUT_SEL_RST(16'h0000)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .write_n(write_n), .read_n(read_n),
    .data_in(data_in), .data_out(data_out), .gpio_in(gpio_in), .func_out(func_out),
    .pad_out(pad_out), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write lands on the next rising edge; returns at the following falling edge
  task automatic bus_write(input logic [3:0] idx, input logic [31:0] d, input logic [1:0] wn);
    @(negedge clk);
    sel = 1'b1; addr = {idx, 2'b00}; write_n = wn; data_in = d;
    @(negedge clk);
    sel = 1'b0; write_n = 2'b11; data_in = '0;
  endtask

  task automatic read_reg(input logic [3:0] idx, output logic [31:0] val);
    sel = 1'b1; addr = {idx, 2'b00}; read_n = 2'b00;
    #1 val = data_out;
    sel = 1'b0; read_n = 2'b11;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; addr = '0; write_n = 2'b11; read_n = 2'b11; data_in = '0;
    gpio_in = 8'hFF; func_out = 8'h5A;
    repeat (3) @(negedge clk);

    // Reset state
    read_reg(4'd0, v); check("rst_out", v, 32'h0);
    read_reg(4'd8, v); check("rst_pend", v, 32'h0);
    read_reg(4'd1, v); check("rst_in", v, 32'h0);
    read_reg(4'd5, v); check("rst_out_sel", v, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_pad", 32'(pad_out), 32'h5A);

    // Pins high through reset: IN follows after two clocks, no blanked rising events
    rst = 1'b0;
    @(negedge clk); read_reg(4'd1, v); check("in_after_1clk", v, 32'h0);
    @(negedge clk); read_reg(4'd1, v); check("in_after_2clk", v, 32'hFF);
    bus_write(4'd6, 32'hFF, 2'b10);
    repeat (4) @(negedge clk);
    read_reg(4'd8, v); check("blank_pend", v, 32'h0);
    check("blank_irq", 32'(irq), 32'h0);

    // Output register and atomic aliases
    exp_out = 8'h0F;          bus_write(4'd0, 32'h0F, 2'b10);
    exp_out = exp_out | 8'h30; bus_write(4'd2, 32'h30, 2'b10);
    exp_out = exp_out & ~8'h03; bus_write(4'd3, 32'h03, 2'b10);
    exp_out = exp_out ^ 8'h81; bus_write(4'd4, 32'h81, 2'b10);
    read_reg(4'd0, v); check("out_ops", v, 32'h0000_00BD);
    read_reg(4'd3, v); check("alias_read", v, 32'(exp_out));
    check("pad_func", 32'(pad_out), 32'h5A);
    bus_write(4'd5, 32'hFF, 2'b10);
    check("pad_gpio", 32'(pad_out), 32'(exp_out));
    bus_write(4'd5, 32'h0F, 2'b00);
    check("pad_mixed", 32'(pad_out), 32'h5D);
    bus_write(4'd0, 32'hFFFF_FF00, 2'b10);
    read_reg(4'd0, v); check("out_upper_ignored", v, 32'h0);
    bus_write(4'd0, 32'h1234_56A5, 2'b01);
    read_reg(4'd0, v); check("out_half", v, 32'hA5);
    bus_write(4'd12, 32'h0, 2'b10);
    read_reg(4'd0, v); check("unmapped_write", v, 32'hA5);
    read_reg(4'd9, v); check("unmapped_read", v, 32'hFFFF_FFFF);
    addr = '0; sel = 1'b0; #1 check("no_sel_read", data_out, 32'hFFFF_FFFF);

    // Pin2 falling edge latency and W1C
    bus_write(4'd7, 32'h10, 2'b10);
    bus_write(4'd6, 32'hFFFF_FF04, 2'b10);
    read_reg(4'd6, v); check("irq_en_upper", v, 32'h04);
    gpio_in = 8'hFB;
    repeat (2) @(negedge clk);
    read_reg(4'd8, v); check("fall_t2_pend", v, 32'h0);
    check("fall_t2_irq", 32'(irq), 32'h0);
    @(negedge clk);
    read_reg(4'd8, v); check("fall_t3_pend", v, 32'h04);
    check("fall_t3_irq", 32'(irq), 32'h1);
    bus_write(4'd8, 32'h04, 2'b10);
    read_reg(4'd8, v); check("w1c_pend", v, 32'h0);
    check("w1c_irq", 32'(irq), 32'h0);

    // Pin6 rising edge pends but is masked from irq
    gpio_in = 8'hBB; repeat (4) @(negedge clk);
    gpio_in = 8'hFB; repeat (4) @(negedge clk);
    read_reg(4'd8, v); check("masked_pend", v, 32'h40);
    check("masked_irq", 32'(irq), 32'h0);
    bus_write(4'd8, 32'h40, 2'b10);

    // Pin0 rising edge in the same cycle as its W1C
    gpio_in = 8'hFA; repeat (4) @(negedge clk);
    gpio_in = 8'hFB;
    @(negedge clk);
    bus_write(4'd8, 32'h01, 2'b10);
    read_reg(4'd8, v); check("set_beats_clr", v, 32'h01);
    bus_write(4'd8, 32'h01, 2'b10);
    read_reg(4'd8, v); check("clr_pin0", v, 32'h0);

    // Pin5 level mode
    bus_write(4'd7, 32'h0000_0C10, 2'b10);
    repeat (2) @(negedge clk);
    read_reg(4'd8, v); check("level_high", v, 32'h20);
    bus_write(4'd8, 32'h20, 2'b10);
    read_reg(4'd8, v); check("level_w1c_noeffect", v, 32'h20);
    gpio_in = 8'hDB;
    repeat (2) @(negedge clk);
    read_reg(4'd8, v); check("level_low_t2", v, 32'h20);
    @(negedge clk);
    read_reg(4'd8, v); check("level_low_t3", v, 32'h0);
    bus_write(4'd7, 32'h1234_5678, 2'b00);
    read_reg(4'd7, v); check("mode_byte", v, 32'h0000_0C78);
    read_reg(4'd8, v); check("mode_change_no_event", v, 32'h0);

    // Pin2 now level mode: raise it, then reset mid-operation
    gpio_in = 8'hDF;
    repeat (3) @(negedge clk);
    read_reg(4'd8, v); check("pin2_level", v, 32'h04);
    check("pin2_irq", 32'(irq), 32'h1);
    rst = 1'b1; gpio_in = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    read_reg(4'd8, v); check("mid_rst_pend", v, 32'h0);
    read_reg(4'd0, v); check("mid_rst_out", v, 32'h0);
    read_reg(4'd7, v); check("mid_rst_mode", v, 32'h0);
    read_reg(4'd6, v); check("mid_rst_irq_en", v, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_pad", 32'(pad_out), 32'h5A);
    repeat (6) @(negedge clk);
    read_reg(4'd8, v); check("reblank_pend", v, 32'h0);
    read_reg(4'd1, v); check("reblank_in", v, 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
